// File: rtl/lsu_align_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : funct3 codes, LSU FSM state type and size/lane helper functions.
// Revision: 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_HI = 2'd1,
        ST_RD_LO = 2'd2,
        ST_RD_HI = 2'd3
    } lsu_state_t;

    // Access size in bytes: 1, 2 or 4.
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input logic [2:0] size);
        case (size)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_split(input logic [1:0] off, input logic [2:0] f3);
        return (({1'b0, off}) + size_of(f3)) > 3'd4;
    endfunction

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module  : lsu_load_extend
// Brief   : Selects byte/half/word at a byte offset in a 64-bit window and extends it.
// Revision: 1.0
// ============================================================================
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] i_window,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_word;

    always_comb begin
        w_word = 32'(i_window >> {i_off, 3'b000});
        case (i_funct3)
            F3_B:    o_data = {{24{w_word[7]}}, w_word[7:0]};
            F3_BU:   o_data = {24'h0, w_word[7:0]};
            F3_H:    o_data = {{16{w_word[15]}}, w_word[15:0]};
            F3_HU:   o_data = {16'h0, w_word[15:0]};
            default: o_data = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align_unit
// Brief   : Load/store alignment unit; splits word-crossing accesses into two words.
// Revision: 1.0
// ============================================================================
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS       = 9,
    parameter int DATA_W           = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  load_valid,
    output logic [DATA_W-1:0]     load_data,
    output logic                  err
);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic                  r_split;
    logic [2:0]            r_funct3;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_lo_buf;
    logic [31:0]           r_load_data;
    logic                  r_load_valid;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_req_split;
    logic                  w_req_err;
    logic                  w_go_store;
    logic                  w_go_load;
    logic                  w_load_done;
    logic [2:0]            w_st_f3;
    logic [1:0]            w_st_off;
    logic [31:0]           w_st_data;
    logic [7:0]            w_be_wide;
    logic [63:0]           w_wd_wide;
    logic [DM_ADDRESS-1:0] w_req_word0;
    logic [DM_ADDRESS-1:0] w_hold_word0;
    logic [DM_ADDRESS-1:0] w_hold_word1;
    logic [63:0]           w_window;
    logic [31:0]           w_ext;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_req_split = is_split(req_addr[1:0], req_funct3);
    assign w_req_err   = (req_load && req_store)
                       || (req_load  && !load_legal(req_funct3))
                       || (req_store && !store_legal(req_funct3))
                       || ((ALLOW_MISALIGNED == 0) && w_req_split && (req_load || req_store));
    assign w_go_store  = w_accept && req_store && !w_req_err;
    assign w_go_load   = w_accept && req_load  && !w_req_err;
    assign w_load_done = ((r_state == ST_RD_LO) && !r_split) || (r_state == ST_RD_HI);

    assign w_req_word0  = {req_addr[DM_ADDRESS-1:2], 2'b00};
    assign w_hold_word0 = {r_addr[DM_ADDRESS-1:2], 2'b00};
    assign w_hold_word1 = w_hold_word0 + DM_ADDRESS'(4);

    // One shifter serves both halves: the low word comes from the live request,
    // the high word from the held request while in WR_HI.
    assign w_st_f3   = (r_state == ST_WR_HI) ? r_funct3    : req_funct3;
    assign w_st_off  = (r_state == ST_WR_HI) ? r_addr[1:0] : req_addr[1:0];
    assign w_st_data = (r_state == ST_WR_HI) ? r_wdata     : req_wdata;
    assign w_be_wide = {4'b0000, mask_of(size_of(w_st_f3))} << w_st_off;
    assign w_wd_wide = {32'h0, w_st_data} << {w_st_off, 3'b000};

    assign w_window = (r_state == ST_RD_HI) ? {mem_rdata, r_lo_buf} : {32'h0, mem_rdata};

    lsu_load_extend u_extend (
        .i_window (w_window),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go_store && w_req_split) begin
                    w_next = ST_WR_HI;
                end else if (w_go_load) begin
                    w_next = ST_RD_LO;
                end
            end
            ST_WR_HI: w_next = ST_IDLE;
            ST_RD_LO: w_next = r_split ? ST_RD_HI : ST_IDLE;
            ST_RD_HI: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        mem_addr  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_go_store) begin
                    mem_we    = 1'b1;
                    mem_addr  = w_req_word0;
                    mem_be    = w_be_wide[3:0];
                    mem_wdata = w_wd_wide[31:0];
                end else if (w_go_load) begin
                    mem_re   = 1'b1;
                    mem_addr = w_req_word0;
                end
            end
            ST_WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = w_hold_word1;
                mem_be    = w_be_wide[7:4];
                mem_wdata = w_wd_wide[63:32];
            end
            ST_RD_LO: begin
                if (r_split) begin
                    mem_re   = 1'b1;
                    mem_addr = w_hold_word1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_split      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_lo_buf     <= 32'h0;
            r_load_data  <= 32'h0;
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_split  <= w_req_split;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (r_state == ST_RD_LO) begin
                r_lo_buf <= mem_rdata;
            end
            if (w_load_done) begin
                r_load_data <= w_ext;
            end
            r_load_valid <= w_load_done;
            r_err        <= w_accept && w_req_err;
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign load_valid = r_load_valid;
    assign load_data  = r_load_data;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_align_unit
// Brief   : Self-checking bench: directed timing sequences plus a vector table.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_align_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, mem_re, mem_we, load_valid, err;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, load_data;
    logic [31:0] mem_rdata = 32'h0;

    logic        req_valid_nm;
    logic        req_ready_nm, mem_re_nm, mem_we_nm, load_valid_nm, err_nm;
    logic [8:0]  mem_addr_nm;
    logic [3:0]  mem_be_nm;
    logic [31:0] mem_wdata_nm, load_data_nm;

    always #5 clk = ~clk;

    lsu_align_unit #(.DM_ADDRESS(9), .DATA_W(32), .ALLOW_MISALIGNED(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .load_valid(load_valid), .load_data(load_data), .err(err)
    );

    lsu_align_unit #(.DM_ADDRESS(9), .DATA_W(32), .ALLOW_MISALIGNED(0)) u_dut_nm (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_nm), .req_ready(req_ready_nm),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(mem_addr_nm),
        .mem_re(mem_re_nm), .mem_we(mem_we_nm), .mem_be(mem_be_nm), .mem_wdata(mem_wdata_nm),
        .mem_rdata(32'h0), .load_valid(load_valid_nm), .load_data(load_data_nm), .err(err_nm)
    );

    // Word-wide memory: read data is valid the cycle after mem_re.
    logic [31:0] mem [0:127];
    logic        mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[3] <= 32'h44332211;
            mem[4] <= 32'h88776655;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
        end
    end

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        string       name;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
        string       name;
    } vec_t;
    vec_t tbl[$];

    int n_vec = 0;
    int n_err = 0;

    logic        s_re, s_we;
    logic [3:0]  s_be;
    logic [8:0]  s_addr;
    logic [31:0] s_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (load_valid || err)) begin
                if (sbq.size() == 0) begin
                    check("spurious load_valid/err", {30'b0, load_valid, err}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_err) begin
                        check({e.name, " flags"}, {30'b0, load_valid, err}, 32'h1);
                    end else begin
                        check({e.name, " flags"}, {30'b0, load_valid, err}, 32'h2);
                        check({e.name, " data"}, load_data, e.data);
                    end
                end
            end
        end
    endtask

    task automatic add(input logic ld, input logic st, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd, input logic ee, input logic [31:0] ed, input string nm);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_err = ee; v.exp_data = ed; v.name = nm;
        tbl.push_back(v);
    endtask

    // Drives one request and waits (bounded) for acceptance; snapshots mem_* in the accept cycle.
    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd, input logic push, input logic ee,
                          input logic [31:0] ed, input string nm);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        req_load = ld; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " ready"}, {31'b0, req_ready}, 32'h1);
        s_re = mem_re; s_we = mem_we; s_be = mem_be; s_addr = mem_addr; s_wdata = mem_wdata;
        if (push) begin
            e.is_err = ee; e.data = ed; e.name = nm;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic reload_mem();
        @(posedge clk);
        #1 mem_init = 1'b1;
        @(posedge clk);
        #1 mem_init = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_valid_nm = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = 9'h0; req_wdata = 32'h0;
        fork monitor(); join_none

        repeat (2) @(negedge clk);
        check("rst ready", {31'b0, req_ready}, 32'h1);
        check("rst strobes", {28'b0, mem_re, mem_we, load_valid, err}, 32'h0);
        check("rst load_data", load_data, 32'h0);
        rst_n = 1'b1;
        mem_init = 1'b0;

        // Aligned word store: single cycle, ready stays high.
        do_req(1'b0, 1'b1, F3_W, 9'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "sw");
        check("sw we", {31'b0, s_we}, 32'h1);
        check("sw be", {28'b0, s_be}, 32'hF);
        check("sw addr", {23'b0, s_addr}, 32'h010);
        check("sw wdata", s_wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("sw after", {30'b0, req_ready, mem_we}, 32'h2);

        do_req(1'b0, 1'b1, F3_B, 9'h013, 32'h000000A5, 1'b0, 1'b0, 32'h0, "sb");
        check("sb be", {28'b0, s_be}, 32'h8);
        check("sb wdata", s_wdata, 32'hA5000000);
        do_req(1'b1, 1'b0, F3_B,  9'h013, 32'h0, 1'b1, 1'b0, 32'hFFFFFFA5, "lb");
        do_req(1'b1, 1'b0, F3_BU, 9'h013, 32'h0, 1'b1, 1'b0, 32'h000000A5, "lbu");

        // Split word load: two reads, ready low for two cycles, result at T+3.
        reload_mem();
        do_req(1'b1, 1'b0, F3_W, 9'h00E, 32'h0, 1'b1, 1'b0, 32'h66554433, "lw split");
        check("lw split rd0", {22'b0, s_re, s_addr}, {22'b0, 1'b1, 9'h00C});
        @(negedge clk);
        check("lw split rd1", {21'b0, req_ready, mem_re, mem_addr}, {21'b0, 1'b0, 1'b1, 9'h010});
        @(negedge clk);
        check("lw split T+2", {30'b0, req_ready, load_valid}, 32'h0);
        @(negedge clk);
        check("lw split T+3", {30'b0, req_ready, load_valid}, 32'h3);

        // Split half store wrapping from the top word to address 0.
        do_req(1'b0, 1'b1, F3_H, 9'h1FF, 32'h0000BEEF, 1'b0, 1'b0, 32'h0, "sh wrap");
        check("sh wrap lo", {s_we, s_be, s_addr}, {1'b1, 4'h8, 9'h1FC});
        check("sh wrap lo data", s_wdata, 32'hEF000000);
        @(negedge clk);
        check("sh wrap hi", {req_ready, mem_we, mem_be, mem_addr}, {1'b0, 1'b1, 4'h1, 9'h000});
        check("sh wrap hi data", mem_wdata, 32'h000000BE);

        // Illegal funct3 load: no memory access, err at T+1.
        do_req(1'b1, 1'b0, 3'b011, 9'h000, 32'h0, 1'b1, 1'b1, 32'h0, "ld f3=011");
        check("ld f3=011 strobes", {30'b0, s_re, s_we}, 32'h0);
        @(negedge clk);
        check("ld f3=011 T+1", {30'b0, req_ready, err}, 32'h3);

        // Misaligned word load on the non-splitting instance.
        @(posedge clk);
        #1;
        req_load = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 9'h002;
        req_valid_nm = 1'b1;
        @(negedge clk);
        check("nm accept", {30'b0, req_ready_nm, mem_re_nm}, 32'h2);
        @(posedge clk);
        #1 req_valid_nm = 1'b0;
        @(negedge clk);
        check("nm T+1", {29'b0, mem_re_nm, load_valid_nm, err_nm}, 32'h1);
        @(negedge clk);
        check("nm T+2", {29'b0, mem_re_nm, load_valid_nm, err_nm}, 32'h0);

        // Reset while in RD_HI aborts the load with no load_valid.
        reload_mem();
        do_req(1'b1, 1'b0, F3_W, 9'h00E, 32'h0, 1'b0, 1'b0, 32'h0, "lw reset");
        @(negedge clk);
        @(negedge clk);
        check("lw reset in RD_HI", {31'b0, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("lw reset ready", {30'b0, req_ready, load_valid}, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("lw reset no valid", {30'b0, req_ready, load_valid}, 32'h2);
        end

        reload_mem();
        add(0, 1, F3_W,   9'h020, 32'hDEADBEEF, 0, 32'h0,        "t sw 020");
        add(1, 0, F3_W,   9'h020, 32'h0,        0, 32'hDEADBEEF, "t lw 020");
        add(0, 1, F3_B,   9'h013, 32'h000000A5, 0, 32'h0,        "t sb 013");
        add(1, 0, F3_B,   9'h013, 32'h0,        0, 32'hFFFFFFA5, "t lb 013");
        add(1, 0, F3_BU,  9'h013, 32'h0,        0, 32'h000000A5, "t lbu 013");
        add(1, 0, F3_H,   9'h012, 32'h0,        0, 32'hFFFFA577, "t lh 012");
        add(1, 0, F3_HU,  9'h012, 32'h0,        0, 32'h0000A577, "t lhu 012");
        add(1, 0, F3_W,   9'h00E, 32'h0,        0, 32'h66554433, "t lw 00E");
        add(1, 0, F3_B,   9'h00D, 32'h0,        0, 32'h00000022, "t lb 00D");
        add(0, 1, F3_H,   9'h1FF, 32'h0000BEEF, 0, 32'h0,        "t sh 1FF");
        add(1, 0, F3_HU,  9'h1FF, 32'h0,        0, 32'h0000BEEF, "t lhu 1FF");
        add(1, 0, F3_H,   9'h1FF, 32'h0,        0, 32'hFFFFBEEF, "t lh 1FF");
        add(1, 0, F3_W,   9'h1FC, 32'h0,        0, 32'hEF000000, "t lw 1FC");
        add(1, 0, F3_B,   9'h000, 32'h0,        0, 32'hFFFFFFBE, "t lb 000");
        add(0, 1, F3_W,   9'h031, 32'h11223344, 0, 32'h0,        "t sw 031");
        add(1, 0, F3_W,   9'h031, 32'h0,        0, 32'h11223344, "t lw 031");
        add(1, 0, F3_W,   9'h030, 32'h0,        0, 32'h22334400, "t lw 030");
        add(1, 0, F3_H,   9'h033, 32'h0,        0, 32'h00001122, "t lh 033");
        add(1, 0, 3'b011, 9'h000, 32'h0,        1, 32'h0,        "t ld f3 011");
        add(0, 1, F3_BU,  9'h004, 32'h0,        1, 32'h0,        "t st f3 100");
        add(1, 1, F3_W,   9'h008, 32'h0,        1, 32'h0,        "t ld+st");
        add(1, 0, 3'b111, 9'h000, 32'h0,        1, 32'h0,        "t ld f3 111");
        add(1, 0, F3_HU,  9'h013, 32'h0,        0, 32'h000000A5, "t lhu 013");
        add(1, 0, F3_BU,  9'h1FF, 32'h0,        0, 32'h000000EF, "t lbu 1FF");

        foreach (tbl[i]) begin
            do_req(tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                   tbl[i].ld | tbl[i].exp_err, tbl[i].exp_err, tbl[i].exp_data, tbl[i].name);
            if (tbl[i].exp_err)
                check({tbl[i].name, " strobes"}, {30'b0, s_re, s_we}, 32'h0);
            else if (tbl[i].ld)
                check({tbl[i].name, " rd addr"}, {22'b0, s_re, s_addr},
                      {22'b0, 1'b1, tbl[i].addr[8:2], 2'b00});
        end

        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
        check("scoreboard drained", sbq.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
